clk_monitor: RTL and testbench

Frequency and duty-cycle checker for the divided clocks produced by the clock-divider stage. It samples a monitored clock (for example a divide-by-3 output) in the fast reference clock domain and measures each period and high time in reference cycles. It checks each period against a programmed window and raises sticky fault flags. It sits directly downstream of the divider and feeds clock-health status to control logic.

---
 rtl/clk_monitor.sv | 122 ++++++++++++
 tb/tb_clk_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - period/duty checker for a divided clock; CLK_MON_DUTY_EN builds the high-time counter
module clk_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period_min,
    input  logic [CNT_W-1:0] period_max,
    input  logic [CNT_W-1:0] timeout,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   mon_s;
    logic                   mon_d;
    logic                   rise;
    logic                   active;
    logic                   tmo_hit;
    logic                   meas_hit;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;

    assign mon_s  = sync_q[SYNC_STAGES-1];
    assign rise   = mon_s & ~mon_d;
    assign active = (state != IDLE);

    // An edge always wins over a coincident timeout.
    assign tmo_hit  = en && active && !rise && (timeout != '0) && (cnt == timeout);
    assign meas_hit = en && (state == MEASURE) && rise;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM: begin
                if (rise)         state_nxt = MEASURE;
                else if (tmo_hit) state_nxt = ARM;
            end
            MEASURE: if (tmo_hit) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (!en || !active)       cnt_nxt = '0;
        else if (rise)            cnt_nxt = CNT_ONE;
        else if (tmo_hit)         cnt_nxt = '0;
        else if (cnt != CNT_MAX)  cnt_nxt = cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            mon_d      <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            too_fast   <= 1'b0;
            too_slow   <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            mon_d      <= mon_s;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            meas_valid <= meas_hit;
            if (meas_hit) period <= cnt;
            // Set terms are ORed after the clear so a same-cycle violation keeps the flag.
            too_fast   <= (meas_hit && (cnt < period_min)) | (too_fast & ~clr);
            too_slow   <= (meas_hit && (cnt > period_max)) | (too_slow & ~clr);
            stuck      <= tmo_hit | (stuck & ~clr);
        end
    end

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nxt;

    always_comb begin
        hcnt_nxt = hcnt;
        if (!en || !active)                hcnt_nxt = '0;
        else if (rise)                     hcnt_nxt = CNT_ONE;
        else if (mon_s && hcnt != CNT_MAX) hcnt_nxt = hcnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            hcnt <= hcnt_nxt;
            if (meas_hit) high_time <= hcnt;
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - randomized and directed bench for clk_monitor against an edge-level reference model
module tb_clk_monitor;

    localparam int S     = 2;
    localparam int P4MIN = 2;
    localparam int P4MAX = 14;
`ifdef CLK_MON_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mon_clk = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] period_min, period_max, timeout;
    logic [15:0] period, high_time;
    logic        meas_valid, too_fast, too_slow, stuck;
    logic [3:0]  period_min4, period_max4, timeout4;
    logic [3:0]  period4, high_time4;
    logic        meas_valid4, too_fast4, too_slow4, stuck4;

    int errors = 0;
    int checks = 0;
    int next_pmin = 5;
    int next_pmax = 7;
    int next_tmo  = 0;

    bit hist[$];
    bit m_active[2], m_started[2], m_valid[2], m_fast[2], m_slow[2], m_stuck[2];
    int m_cnt[2], m_hcnt[2], m_period[2], m_high[2];

    always #5 clk = ~clk;

    clk_monitor #(.CNT_W(16), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .en(en), .clr(clr),
        .period_min(period_min), .period_max(period_max), .timeout(timeout),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .too_fast(too_fast), .too_slow(too_slow), .stuck(stuck)
    );

    clk_monitor #(.CNT_W(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .en(en), .clr(clr),
        .period_min(period_min4), .period_max(period_max4), .timeout(timeout4),
        .period(period4), .high_time(high_time4), .meas_valid(meas_valid4),
        .too_fast(too_fast4), .too_slow(too_slow4), .stuck(stuck4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit hv(input int idx);
        return (idx >= 0 && idx < hist.size()) ? hist[idx] : 1'b0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_started[i] = 0; m_valid[i] = 0;
            m_fast[i] = 0; m_slow[i] = 0; m_stuck[i] = 0;
            m_cnt[i] = 0; m_hcnt[i] = 0; m_period[i] = 0; m_high[i] = 0;
        end
    endtask

    // One reference-clock edge: r/hi describe the synchronized monitored clock seen at that edge.
    task automatic model_edge(input int i, input bit e, input bit c, input bit r, input bit hi,
                              input int maxv, input int pmin, input int pmax, input int tmo);
        bit sf, ss, st;
        sf = 0; ss = 0; st = 0;
        m_valid[i] = 0;
        if (!e) begin
            m_active[i] = 0; m_started[i] = 0; m_cnt[i] = 0; m_hcnt[i] = 0;
        end else if (!m_active[i]) begin
            m_active[i] = 1; m_started[i] = 0; m_cnt[i] = 0; m_hcnt[i] = 0;
        end else if (r) begin
            if (m_started[i]) begin
                m_valid[i]  = 1;
                m_period[i] = m_cnt[i];
                m_high[i]   = DUTY ? m_hcnt[i] : 0;
                sf = (m_cnt[i] < pmin);
                ss = (m_cnt[i] > pmax);
            end
            m_started[i] = 1; m_cnt[i] = 1; m_hcnt[i] = 1;
        end else if (tmo != 0 && m_cnt[i] == tmo) begin
            st = 1; m_started[i] = 0; m_cnt[i] = 0;
            m_hcnt[i] = sat(m_hcnt[i] + int'(hi), maxv);
        end else begin
            m_cnt[i]  = sat(m_cnt[i] + 1, maxv);
            m_hcnt[i] = sat(m_hcnt[i] + int'(hi), maxv);
        end
        m_fast[i]  = sf | (m_fast[i] & ~c);
        m_slow[i]  = ss | (m_slow[i] & ~c);
        m_stuck[i] = st | (m_stuck[i] & ~c);
    endtask

    task automatic compare_all();
        chk("valid",     meas_valid,  m_valid[0]);
        chk("period",    period,      m_period[0]);
        chk("high_time", high_time,   m_high[0]);
        chk("too_fast",  too_fast,    m_fast[0]);
        chk("too_slow",  too_slow,    m_slow[0]);
        chk("stuck",     stuck,       m_stuck[0]);
        chk("valid4",    meas_valid4, m_valid[1]);
        chk("period4",   period4,     m_period[1]);
        chk("high4",     high_time4,  m_high[1]);
        chk("too_fast4", too_fast4,   m_fast[1]);
        chk("too_slow4", too_slow4,   m_slow[1]);
        chk("stuck4",    stuck4,      m_stuck[1]);
    endtask

    task automatic step(input bit e, input bit c, input bit mv);
        int idx;
        @(negedge clk);
        compare_all();
        en = e; clr = c; mon_clk = mv;
        period_min = 16'(next_pmin); period_max = 16'(next_pmax); timeout = 16'(next_tmo);
        hist.push_back(mv);
        idx = hist.size() - 1 - S;
        model_edge(0, e, c, hv(idx) & ~hv(idx - 1), hv(idx), 65535, next_pmin, next_pmax, next_tmo);
        model_edge(1, e, c, hv(idx) & ~hv(idx - 1), hv(idx), 15, P4MIN, P4MAX, 0);
    endtask

    task automatic run_wave(input int n, input int h, input int count, input int cp);
        for (int k = 0; k < count; k++)
            for (int p = 0; p < n; p++)
                step(1'b1, (p == cp), (p < h));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},  meas_valid, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high"},   high_time, 0);
        chk({tag, "_fast"},   too_fast, 0);
        chk({tag, "_slow"},   too_slow, 0);
        chk({tag, "_stuck"},  stuck, 0);
        chk({tag, "_period4"}, period4, 0);
        chk({tag, "_slow4"},  too_slow4, 0);
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        reset_model();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compare_all();
            en = 1'b1; clr = 1'b0; mon_clk = 1'b0;
            hist.push_back(1'b0);
        end
        for (int k = 0; k < hist.size(); k++) hist[k] = 1'b0;
        #2 rst_n = 1'b1;
        model_edge(0, 1'b1, 1'b0, 1'b0, 1'b0, 65535, next_pmin, next_pmax, next_tmo);
        model_edge(1, 1'b1, 1'b0, 1'b0, 1'b0, 15, P4MIN, P4MAX, 0);
    endtask

    initial begin
        int n, h, cp;
        period_min = 16'd5; period_max = 16'd7; timeout = 16'd0;
        period_min4 = 4'(P4MIN); period_max4 = 4'(P4MAX); timeout4 = 4'd0;
        reset_model();
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // divide-by-3 output: period 6, 2 high
        next_pmin = 5; next_pmax = 7; next_tmo = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        run_wave(6, 2, 8, -1);
        chk("div3_period", period, 6);
        chk("div3_high", high_time, DUTY ? 2 : 0);
        chk("div3_flags", {too_fast, too_slow, stuck}, 0);

        // too fast, clear, re-set, and clear coinciding with a violating edge
        step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        run_wave(4, 2, 4, -1);
        chk("fast_set", too_fast, 1);
        run_wave(4, 2, 1, 3);
        step(1'b1, 1'b0, 1'b1);
        chk("fast_cleared", too_fast, 0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("fast_reset", too_fast, 1);
        run_wave(4, 2, 3, 2);
        chk("fast_clr_same_cycle", too_fast, 1);

        // stuck clock
        step(1'b1, 1'b1, 1'b0);
        next_tmo = 20;
        step(1'b0, 1'b0, 1'b0);
        repeat (60) step(1'b1, 1'b0, 1'b0);
        chk("stuck_set", stuck, 1);
        chk("stuck_no_fast", too_fast, 0);
        run_wave(6, 2, 3, -1);

        // saturation on the 4-bit instance
        next_tmo = 0;
        step(1'b1, 1'b1, 1'b0);
        run_wave(40, 10, 3, -1);
        chk("sat_period4", period4, 15);
        chk("sat_slow4", too_slow4, 1);
        chk("sat_period16", period, 40);

        // enable dropped mid-period, then restored while mon_clk is high
        step(1'b1, 1'b1, 1'b0);
        run_wave(6, 2, 3, -1);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        run_wave(6, 3, 3, -1);
        chk("reen_period", period, 6);
        chk("reen_high", high_time, DUTY ? 3 : 0);

        // randomized waveforms, limits, timeouts and clears
        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(2, 30);
            h = $urandom_range(1, n - 1);
            next_pmin = $urandom_range(2, 30);
            next_pmax = next_pmin + $urandom_range(0, 10);
            next_tmo  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 40);
            cp = $urandom_range(0, n + 3);
            if (cp >= n) cp = -1;
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b0);
            end
            run_wave(n, h, $urandom_range(2, 6), cp);
        end

        // asynchronous reset during a measurement
        next_pmin = 5; next_pmax = 7; next_tmo = 0;
        step(1'b1, 1'b1, 1'b0);
        run_wave(6, 2, 3, -1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        reset_mid();
        repeat (2) step(1'b1, 1'b0, 1'b0);
        run_wave(6, 2, 5, -1);
        chk("post_rst_period", period, 6);
        chk("post_rst_flags", {too_fast, too_slow, stuck}, 0);
        step(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
